// File: rtl/feeder_pkg.sv
// Definitions shared by the feed scheduler and the feeder motor controller:
// the scheduler state encoding and the common clock rate that defines one second.
package feeder_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    COOLDOWN = 2'd2
  } feed_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: tick pulses for one cycle every CLK_HZ cycles.
// A synchronous clear restarts the second so the caller can align it to an event.
module sec_tick #(
  parameter int CLK_HZ = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/feed_scheduler.sv
// Decides when the feeder runs: manual button or auto interval starts a feed,
// activate is held for FEED_SEC seconds, then a cooldown locks out new triggers.
module feed_scheduler
  import feeder_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int FEED_SEC     = 5,
  parameter int COOLDOWN_SEC = 10,
  parameter int INTERVAL_W   = 16,
  parameter int COUNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  manual_btn,
  input  logic [INTERVAL_W-1:0] interval_sec,
  output logic                  activate,
  output logic                  busy,
  output logic [COUNT_W-1:0]    feed_count,
  output logic [INTERVAL_W-1:0] next_feed_sec
);

  localparam int SEC_MAX = max_int(FEED_SEC, COOLDOWN_SEC);
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam logic [SEC_W-1:0] FEED_LAST = SEC_W'(FEED_SEC - 1);
  localparam logic [SEC_W-1:0] COOL_LAST = SEC_W'((COOLDOWN_SEC > 0) ? COOLDOWN_SEC - 1 : 0);

  feed_state_t           state_reg;
  logic                  activate_reg;
  logic                  busy_reg;
  logic [COUNT_W-1:0]    feed_count_reg;
  logic [INTERVAL_W-1:0] countdown_reg;
  logic [INTERVAL_W-1:0] next_feed_reg;
  logic [SEC_W-1:0]      sec_reg;
  logic                  sync1_reg;
  logic                  sync2_reg;
  logic                  prev_reg;

  logic tick;
  logic man_edge;
  logic auto_active;
  logic auto_fire;
  logic trigger;
  logic transition;

  assign man_edge    = sync2_reg & ~prev_reg;
  assign auto_active = enable && (interval_sec != '0);
  assign auto_fire   = auto_active && tick && (countdown_reg == INTERVAL_W'(1));
  assign trigger     = man_edge || auto_fire;

  // Restart the second on every state change so each phase lasts whole seconds.
  always_comb begin
    transition = 1'b0;
    case (state_reg)
      IDLE:     transition = trigger;
      FEED:     transition = tick && (sec_reg == FEED_LAST);
      COOLDOWN: transition = tick && (sec_reg == COOL_LAST);
      default:  transition = 1'b1;
    endcase
  end

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clock(clock),
    .reset(reset),
    .clear(transition),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      activate_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      feed_count_reg <= '0;
      sec_reg        <= '0;
      countdown_reg  <= interval_sec;
      next_feed_reg  <= auto_active ? interval_sec : '0;
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      prev_reg       <= 1'b0;
    end else begin
      sync1_reg <= manual_btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            // Countdown and next_feed_sec stay frozen through the feed.
            state_reg    <= FEED;
            activate_reg <= 1'b1;
            busy_reg     <= 1'b1;
            if (feed_count_reg != {COUNT_W{1'b1}}) begin
              feed_count_reg <= feed_count_reg + 1'b1;
            end
          end else if (!auto_active) begin
            countdown_reg <= interval_sec;
            next_feed_reg <= '0;
          end else if (interval_sec < countdown_reg) begin
            countdown_reg <= interval_sec;
            next_feed_reg <= interval_sec;
          end else if (tick) begin
            countdown_reg <= countdown_reg - 1'b1;
            next_feed_reg <= countdown_reg - 1'b1;
          end else begin
            next_feed_reg <= countdown_reg;
          end
        end
        FEED: begin
          if (tick) begin
            if (sec_reg == FEED_LAST) begin
              sec_reg      <= '0;
              activate_reg <= 1'b0;
              if (COOLDOWN_SEC == 0) begin
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                countdown_reg <= interval_sec;
                next_feed_reg <= auto_active ? interval_sec : '0;
              end else begin
                state_reg <= COOLDOWN;
              end
            end else begin
              sec_reg <= sec_reg + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (sec_reg == COOL_LAST) begin
              sec_reg       <= '0;
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              countdown_reg <= interval_sec;
              next_feed_reg <= auto_active ? interval_sec : '0;
            end else begin
              sec_reg <= sec_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          activate_reg <= 1'b0;
          busy_reg     <= 1'b0;
          sec_reg      <= '0;
        end
      endcase
    end
  end

  assign activate      = activate_reg;
  assign busy          = busy_reg;
  assign feed_count    = feed_count_reg;
  assign next_feed_sec = next_feed_reg;

endmodule
